// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM states, datapath actions and display decode.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP, ST_READY, ST_EXEC, ST_SHOW
   } state_t;

   typedef enum logic [1:0] {
      DISP_OPERANDS = 2'd0,
      DISP_DEC      = 2'd1,
      DISP_LED      = 2'd2
   } disp_mode_t;

   // One datapath action per cycle; the FSM picks it by pulse priority.
   typedef enum logic [3:0] {
      ACT_NONE, ACT_CLEAR, ACT_LOAD_A, ACT_LOAD_B, ACT_SET_OP,
      ACT_START, ACT_TICK, ACT_CAPTURE, ACT_CHAIN
   } act_t;

   localparam logic [3:0] STAT_DEC_HI = 4'b1000;
   localparam logic [3:0] STAT_DEC_LO = 4'b0100;
   localparam logic [3:0] STAT_LED_HI = 4'b0010;
   localparam logic [3:0] STAT_LED_LO = 4'b0001;

   function automatic disp_mode_t status_to_disp(input logic [3:0] status);
      disp_mode_t mode;
      mode = DISP_OPERANDS;
      if (status == STAT_DEC_HI || status == STAT_DEC_LO)
         mode = DISP_DEC;
      else if (status == STAT_LED_HI || status == STAT_LED_LO)
         mode = DISP_LED;
      return mode;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Operator-panel and ALU-facing signals of the sequencer; master is the parent, slave the sequencer.
interface alu_sequencer_if #(parameter int W = 8);

   logic [W-1:0] sw;
   logic         load_pulse;
   logic         op_pulse;
   logic [3:0]   op_in;
   logic         exec_pulse;
   logic         clear_pulse;
   logic [W-1:0] alu_result;
   logic [3:0]   alu_status;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_opcode;
   logic [W-1:0] result_q;
   logic [3:0]   status_q;
   logic [1:0]   disp_mode;
   logic         busy;
   logic         done;
   logic [7:0]   op_count;

   modport master (
      output sw, load_pulse, op_pulse, op_in, exec_pulse, clear_pulse, alu_result, alu_status,
      input  alu_a, alu_b, alu_opcode, result_q, status_q, disp_mode, busy, done, op_count
   );

   modport slave (
      input  sw, load_pulse, op_pulse, op_in, exec_pulse, clear_pulse, alu_result, alu_status,
      output alu_a, alu_b, alu_opcode, result_q, status_q, disp_mode, busy, done, op_count
   );

endinterface

// File: rtl/alu_sequencer.sv
// Steps operand/opcode entry for an external ALU, holds its inputs SETTLE_CYCLES, then captures.
// Pulses are single-cycle; priority clear > exec > op > load, irrelevant pulses are dropped.
module alu_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int W             = 8
) (
   input logic       clk,
   input logic       rst,
   alu_sequencer_if.slave bus
);
   import alu_seq_pkg::*;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   state_t       state_q, state_d;
   act_t         act;
   logic [3:0]   settle_q;
   logic [W-1:0] a_q, b_q, result_r;
   logic [3:0]   opcode_q, status_r;
   logic         done_r;
   logic [7:0]   count_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_WAIT_A;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      act     = ACT_NONE;
      if (bus.clear_pulse) begin
         act     = ACT_CLEAR;
         state_d = ST_WAIT_A;
      end else begin
         case (state_q)
            ST_WAIT_A:  if (bus.load_pulse) begin act = ACT_LOAD_A; state_d = ST_WAIT_B;  end
            ST_WAIT_B:  if (bus.load_pulse) begin act = ACT_LOAD_B; state_d = ST_WAIT_OP; end
            ST_WAIT_OP: if (bus.op_pulse)   begin act = ACT_SET_OP; state_d = ST_READY;   end
            ST_READY: begin
               if (bus.exec_pulse) begin
                  act     = ACT_START;
                  state_d = ST_EXEC;
               end else if (bus.op_pulse) begin
                  act = ACT_SET_OP;
               end
            end
            ST_EXEC: begin
               if (settle_q == 4'd0) begin
                  act     = ACT_CAPTURE;
                  state_d = ST_SHOW;
               end else begin
                  act = ACT_TICK;
               end
            end
            ST_SHOW: begin
               if (bus.op_pulse) begin
                  act     = ACT_CHAIN;
                  state_d = ST_WAIT_B;
               end else if (bus.load_pulse) begin
                  act     = ACT_LOAD_A;
                  state_d = ST_WAIT_B;
               end
            end
            default: state_d = ST_WAIT_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q      <= '0;
         b_q      <= '0;
         opcode_q <= '0;
         result_r <= '0;
         status_r <= '0;
         settle_q <= '0;
         done_r   <= 1'b0;
         count_r  <= '0;
      end else begin
         done_r <= 1'b0;
         case (act)
            ACT_CLEAR: begin
               a_q      <= '0;
               b_q      <= '0;
               opcode_q <= '0;
               result_r <= '0;
               status_r <= '0;
               settle_q <= '0;
            end
            ACT_LOAD_A: a_q      <= bus.sw;
            ACT_LOAD_B: b_q      <= bus.sw;
            ACT_SET_OP: opcode_q <= bus.op_in;
            ACT_START:  settle_q <= SETTLE_INIT;
            ACT_TICK:   settle_q <= settle_q - 4'd1;
            ACT_CAPTURE: begin
               result_r <= bus.alu_result;
               status_r <= bus.alu_status;
               done_r   <= 1'b1;
               if (count_r != 8'hFF) count_r <= count_r + 8'd1;
            end
            ACT_CHAIN: begin
               a_q      <= result_r;
               opcode_q <= bus.op_in;
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_opcode = opcode_q;
   assign bus.result_q   = result_r;
   assign bus.status_q   = status_r;
   assign bus.done       = done_r;
   assign bus.op_count   = count_r;
   assign bus.busy       = (state_q == ST_EXEC);
   assign bus.disp_mode  = (state_q == ST_SHOW) ? status_to_disp(status_r) : DISP_OPERANDS;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table, directed corner sequences, randomized transactions.
module tb_alu_sequencer;

   localparam int W      = 8;
   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sequencer_if #(.W(W)) bus();

   alu_sequencer #(.SETTLE_CYCLES(SETTLE), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural ALU: add, subtract, and, or; anything else xor. Status echoes the opcode.
   function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'b1000: return a + b;
         4'b0100: return a - b;
         4'b0010: return a & b;
         4'b0001: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic int exp_disp(input logic [3:0] s);
      if (s == 4'b1000 || s == 4'b0100) return 1;
      if (s == 4'b0010 || s == 4'b0001) return 2;
      return 0;
   endfunction

   assign bus.alu_result = ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);
   assign bus.alu_status = bus.alu_opcode;

   int errors = 0;
   int checks = 0;
   int m_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Holds the given pulses across exactly one rising edge; returns at the following negedge.
   task automatic drive(input bit ld, input bit op, input bit ex, input bit cl,
                        input logic [7:0] sv, input logic [3:0] ov);
      bus.load_pulse  = ld;
      bus.op_pulse    = op;
      bus.exec_pulse  = ex;
      bus.clear_pulse = cl;
      bus.sw          = sv;
      bus.op_in       = ov;
      @(negedge clk);
      bus.load_pulse  = 1'b0;
      bus.op_pulse    = 1'b0;
      bus.exec_pulse  = 1'b0;
      bus.clear_pulse = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] v);  drive(1, 0, 0, 0, v, 4'h0); endtask
   task automatic do_op(input logic [3:0] o);    drive(0, 1, 0, 0, 8'h00, o); endtask
   task automatic do_exec();                     drive(0, 0, 1, 0, 8'h00, 4'h0); endtask
   task automatic do_clear();                    drive(0, 0, 0, 1, 8'h00, 4'h0); endtask

   task automatic watch(output int bn, output int dn);
      bn = 0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.busy) bn++;
         if (bus.done) dn++;
         @(negedge clk);
      end
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          output int bn, output int dn);
      do_clear();
      do_load(a);
      do_load(b);
      do_op(op);
      do_exec();
      watch(bn, dn);
   endtask

   function automatic int sat_inc(input int c);
      return (c >= 255) ? 255 : c + 1;
   endfunction

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] exp_res;
      logic [3:0] exp_stat;
      int         exp_disp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int bn, dn, b0;
      logic [7:0] m_a, m_b, m_res, ra, rb;
      logic [3:0] m_op, o1, o2;

      vecs[0] = '{8'd25,  8'd17,  4'b1000, 8'd42,  4'b1000, 1};
      vecs[1] = '{8'd50,  8'd8,   4'b0100, 8'd42,  4'b0100, 1};
      vecs[2] = '{8'hF0,  8'h3C,  4'b0010, 8'h30,  4'b0010, 2};
      vecs[3] = '{8'h0F,  8'h30,  4'b0001, 8'h3F,  4'b0001, 2};
      vecs[4] = '{8'h55,  8'h0F,  4'b0000, 8'h5A,  4'b0000, 0};
      vecs[5] = '{8'd200, 8'd100, 4'b1000, 8'd44,  4'b1000, 1};
      vecs[6] = '{8'd3,   8'd5,   4'b0100, 8'd254, 4'b0100, 1};
      vecs[7] = '{8'hAA,  8'hFF,  4'b0011, 8'h55,  4'b0011, 0};

      bus.sw = '0; bus.op_in = '0;
      bus.load_pulse = 0; bus.op_pulse = 0; bus.exec_pulse = 0; bus.clear_pulse = 0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_opcode", bus.alu_opcode, 0);
      chk("rst_result", bus.result_q, 0);
      chk("rst_status", bus.status_q, 0);
      chk("rst_disp", bus.disp_mode, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_count", bus.op_count, 0);
      rst = 1'b1;
      @(negedge clk);

      // Vector table: full load/load/op/exec transactions
      foreach (vecs[i]) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].op, bn, dn);
         m_count = sat_inc(m_count);
         chk($sformatf("vec%0d_busy_cycles", i), bn, SETTLE);
         chk($sformatf("vec%0d_done_pulses", i), dn, 1);
         chk($sformatf("vec%0d_result", i), bus.result_q, vecs[i].exp_res);
         chk($sformatf("vec%0d_status", i), bus.status_q, vecs[i].exp_stat);
         chk($sformatf("vec%0d_disp", i), bus.disp_mode, vecs[i].exp_disp);
         chk($sformatf("vec%0d_count", i), bus.op_count, m_count);
      end

      // Basic sequence then chaining from SHOW
      run_txn(8'd25, 8'd17, 4'b1000, bn, dn);
      m_count = sat_inc(m_count);
      chk("basic_result", bus.result_q, 42);
      chk("basic_disp", bus.disp_mode, 1);
      do_op(4'b0100);
      do_load(8'd2);
      do_exec();
      chk("chain_alu_a", bus.alu_a, 42);
      chk("chain_alu_b", bus.alu_b, 2);
      chk("chain_opcode", bus.alu_opcode, 4'b0100);
      chk("chain_exec_in_wait_op", bus.busy, 0);

      // exec + clear in READY: clear wins, no done, count kept
      do_clear(); do_load(8'd5); do_load(8'd6); do_op(4'b1000);
      drive(0, 0, 1, 1, 8'h00, 4'h0);
      watch(bn, dn);
      chk("excl_busy", bn, 0);
      chk("excl_done", dn, 0);
      chk("excl_count", bus.op_count, m_count);
      chk("excl_alu_a_cleared", bus.alu_a, 0);
      do_load(8'd7);
      chk("excl_back_in_wait_a", bus.alu_a, 7);
      chk("excl_alu_b_untouched", bus.alu_b, 0);

      // load + op in WAIT_OP: only the opcode latches
      do_clear(); do_load(8'h11); do_load(8'h22);
      drive(1, 1, 0, 0, 8'h77, 4'b0100);
      chk("ldop_opcode", bus.alu_opcode, 4'b0100);
      chk("ldop_alu_a", bus.alu_a, 8'h11);
      chk("ldop_alu_b", bus.alu_b, 8'h22);
      do_exec();
      watch(bn, dn);
      m_count = sat_inc(m_count);
      chk("ldop_busy_cycles", bn, SETTLE);
      chk("ldop_result", bus.result_q, 8'hEF);

      // exec/load/op during EXEC are ignored
      do_clear(); do_load(8'd30); do_load(8'd12); do_op(4'b1000);
      do_exec();
      b0 = bus.busy ? 1 : 0;
      drive(1, 1, 1, 0, 8'd99, 4'b0010);
      watch(bn, dn);
      m_count = sat_inc(m_count);
      chk("exec_noise_busy", b0 + bn, SETTLE);
      chk("exec_noise_done", dn, 1);
      chk("exec_noise_alu_a", bus.alu_a, 30);
      chk("exec_noise_opcode", bus.alu_opcode, 4'b1000);
      chk("exec_noise_result", bus.result_q, 42);

      // Randomized transactions against a transaction-level model
      m_res = bus.result_q;
      for (int it = 0; it < 40; it++) begin
         o1 = 4'b1000 >> $urandom_range(0, 4);
         o2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b1000 >> $urandom_range(0, 3));
         rb = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_op(o1);
            m_a = m_res;
            do_load(rb);
            m_b = rb;
            do_op(o2);
            m_op = o2;
         end else begin
            ra = 8'($urandom);
            do_clear();
            drive(0, 1, 1, 0, 8'($urandom), o1);
            do_load(ra);
            do_load(rb);
            do_op(o1);
            do_op(o2);
            m_a = ra; m_b = rb; m_op = o2;
         end
         do_exec();
         b0 = bus.busy ? 1 : 0;
         drive(1, 1, 1, 0, 8'($urandom), 4'($urandom));
         watch(bn, dn);
         m_res = ref_alu(m_op, m_a, m_b);
         m_count = sat_inc(m_count);
         chk($sformatf("rnd%0d_alu_a", it), bus.alu_a, m_a);
         chk($sformatf("rnd%0d_alu_b", it), bus.alu_b, m_b);
         chk($sformatf("rnd%0d_opcode", it), bus.alu_opcode, m_op);
         chk($sformatf("rnd%0d_result", it), bus.result_q, m_res);
         chk($sformatf("rnd%0d_status", it), bus.status_q, m_op);
         chk($sformatf("rnd%0d_disp", it), bus.disp_mode, exp_disp(m_op));
         chk($sformatf("rnd%0d_count", it), bus.op_count, m_count);
         chk($sformatf("rnd%0d_busy", it), b0 + bn, SETTLE);
         chk($sformatf("rnd%0d_done", it), dn, 1);
      end

      // Reset asserted mid-EXEC aborts everything
      do_clear(); do_load(8'd9); do_load(8'd4); do_op(4'b1000);
      do_exec();
      rst = 1'b0;
      #1;
      chk("midrst_alu_a", bus.alu_a, 0);
      chk("midrst_alu_b", bus.alu_b, 0);
      chk("midrst_opcode", bus.alu_opcode, 0);
      chk("midrst_result", bus.result_q, 0);
      chk("midrst_status", bus.status_q, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_disp", bus.disp_mode, 0);
      chk("midrst_count", bus.op_count, 0);
      @(negedge clk);
      rst = 1'b1;
      watch(bn, dn);
      chk("midrst_no_done", dn, 0);
      chk("midrst_no_busy", bn, 0);
      m_count = 0;

      // Saturation of the operation counter
      for (int n = 0; n < 260; n++) begin
         run_txn(8'($urandom), 8'($urandom), 4'b1000, bn, dn);
         m_count = sat_inc(m_count);
         if (n == 254) chk("sat_at_255", bus.op_count, 255);
      end
      chk("sat_after_260", bus.op_count, 255);
      chk("sat_model", bus.op_count, m_count);

      run_txn(8'h01, 8'h02, 4'b0001, bn, dn);
      chk("disp_led_0001", bus.disp_mode, 2);
      chk("disp_led_count", bus.op_count, 255);
      run_txn(8'h01, 8'h02, 4'b0000, bn, dn);
      chk("disp_zero_0000", bus.disp_mode, 0);
      chk("disp_zero_result", bus.result_q, 8'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles the ALU inputs are held stable before the result is captured (legal range 1..15).
REQ-002 Parameter W, default 8, operand and result width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sw  input  W  operand switches, sampled only on a load.
REQ-006 load_pulse  input  1  one-cycle debounced press; loads sw into the current operand slot.
REQ-007 op_pulse  input  1  one-cycle press; latches op_in as the pending opcode.
REQ-008 op_in  input  4  opcode value.
REQ-009 exec_pulse  input  1  one-cycle press; starts execution.
REQ-010 clear_pulse  input  1  one-cycle press; returns the block to the empty state.
REQ-011 alu_result  input  W  result from the combinational ALU.
REQ-012 alu_status  input  4  status from the combinational ALU.
REQ-013 alu_a, alu_b  output  W each  registered operands driving the ALU.
REQ-014 alu_opcode  output  4  registered opcode driving the ALU.
REQ-015 result_q  output  W  captured result.
REQ-016 status_q  output  4  captured status.
REQ-017 disp_mode  output  2  display select: 0 operands, 1 result decimal, 2 result on LEDs.
REQ-018 busy  output  1  high in the EXEC state.
REQ-019 done  output  1  one-cycle pulse on capture.
REQ-020 op_count  output  8  completed-operation counter, saturating.

Function
REQ-021 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, READY, EXEC and SHOW.
REQ-022 WAIT_A -- load_pulse: alu_a<=sw, go to WAIT_B.
REQ-023 WAIT_B -- load_pulse: alu_b<=sw, go to WAIT_OP.
REQ-024 WAIT_OP -- op_pulse: alu_opcode<=op_in, go to READY.
REQ-025 READY -- op_pulse re-latches the opcode and the FSM stays in READY.
REQ-026 READY -- exec_pulse: go to EXEC and load the settle counter with SETTLE_CYCLES-1.
REQ-027 EXEC -- the counter decrements each cycle; when the counter is 0, the block captures result_q<=alu_result and status_q<=alu_status, pulses done for that one edge, and goes to SHOW, for a total of exactly SETTLE_CYCLES cycles in EXEC.
REQ-028 SHOW -- op_pulse chains: alu_a<=result_q, alu_opcode<=op_in, go to WAIT_B.
REQ-029 SHOW -- load_pulse: alu_a<=sw, go to WAIT_B.
REQ-030 disp_mode SHALL be 0 in every state except SHOW.
REQ-031 In SHOW, disp_mode SHALL be set from status_q:
- 1 if status_q is 4'b1000 or 4'b0100;
- 2 if status_q is 4'b0010 or 4'b0001;
- 0 otherwise.
REQ-032 clear_pulse in any state SHALL zero alu_a, alu_b, alu_opcode, result_q and status_q and go to WAIT_A; op_count is kept.
REQ-033 Simultaneous pulses SHALL be resolved by priority clear > exec > op > load, and only one action is taken per cycle.
REQ-034 Pulses not listed for the current state SHALL be ignored; in EXEC every pulse except clear is ignored.
REQ-035 op_count SHALL increment on each done and saturate at 255 with no wrap-around.
REQ-036 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-037 While rst is low:
- state is WAIT_A;
- all registered outputs are 0;
- the settle counter is 0, busy is 0 and done is 0.
REQ-038 A reset asserted mid-EXEC SHALL abort the operation, produce no done pulse and leave op_count at 0.

Structure
REQ-039 The shared package alu_seq_pkg SHALL hold the state enum, the disp_mode enum (DISP_OPERANDS, DISP_DEC, DISP_LED) and the status decode constants.
REQ-040 The block SHALL be a single module with no sub-module; the ALU, debouncers and display logic are instantiated by the parent.

Verification
REQ-041 Basic sequence: load sw=25, load sw=17, op 4'b1000, exec; with SETTLE_CYCLES=2 and the ALU model returning 42 with status 4'b1000 -> busy for 2 cycles, one done pulse, result_q=42, disp_mode=1, op_count=1.
REQ-042 Chaining: from SHOW with result_q=42, op 4'b0100, load sw=2, exec -> alu_a=42, alu_b=2, alu_opcode=4'b0100.
REQ-043 Same-cycle pulses: exec and clear in the same cycle in READY -> state WAIT_A, no done, op_count unchanged; load and op in WAIT_OP -> the opcode is latched and no load occurs.
REQ-044 Mid-EXEC events: rst low during EXEC -> all outputs 0, no done; exec and load pulses during EXEC -> ignored.
REQ-045 Saturation and display decode: 260 executions -> op_count=255; status 4'b0001 -> disp_mode=2; status 4'b0000 -> disp_mode=0.
